// File: rtl/pmem_arbiter.sv
// rtl/pmem_arbiter.sv - shares one physical-memory line port between the I-cache and D-cache miss paths
// Optional registered response path (extra RESP_x cycle, latched rdata): define ARB_RDATA_REG_EN.
module pmem_arbiter #(
  parameter int ADDR_WIDTH   = 16,
  parameter int LINE_WIDTH   = 128,
  parameter int STARVE_LIMIT = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  i_pmem_read,
  input  logic [ADDR_WIDTH-1:0] i_pmem_addr,
  output logic [LINE_WIDTH-1:0] i_pmem_rdata,
  output logic                  i_pmem_resp,
  input  logic                  d_pmem_read,
  input  logic                  d_pmem_write,
  input  logic [ADDR_WIDTH-1:0] d_pmem_addr,
  input  logic [LINE_WIDTH-1:0] d_pmem_wdata,
  output logic [LINE_WIDTH-1:0] d_pmem_rdata,
  output logic                  d_pmem_resp,
  output logic                  pmem_read,
  output logic                  pmem_write,
  output logic [ADDR_WIDTH-1:0] pmem_addr,
  output logic [LINE_WIDTH-1:0] pmem_wdata,
  input  logic [LINE_WIDTH-1:0] pmem_rdata,
  input  logic                  pmem_resp
);

  localparam int CW = $clog2(STARVE_LIMIT + 1);

`ifdef ARB_RDATA_REG_EN
  typedef enum logic [2:0] {IDLE, SERVE_I, SERVE_D, RESP_I, RESP_D} state_t;
`else
  typedef enum logic [1:0] {IDLE, SERVE_I, SERVE_D} state_t;
`endif

  state_t        r_state;
  state_t        w_next;
  logic [CW-1:0] r_starve;
  logic [CW-1:0] w_starve_next;
  logic          w_i_req;
  logic          w_d_req;
  logic          w_force_i;

  assign w_i_req   = i_pmem_read;
  assign w_d_req   = d_pmem_read | d_pmem_write;
  // D normally wins ties; once it has won STARVE_LIMIT contended grants in a row, I goes next.
  assign w_force_i = w_i_req && (r_starve == CW'(STARVE_LIMIT));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state  <= IDLE;
      r_starve <= '0;
    end else begin
      r_state  <= w_next;
      r_starve <= w_starve_next;
    end
  end

`ifdef ARB_RDATA_REG_EN
  logic [LINE_WIDTH-1:0] r_rdata;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rdata <= '0;
    end else if (pmem_resp && (r_state == SERVE_I || r_state == SERVE_D)) begin
      r_rdata <= pmem_rdata;
    end
  end
`endif

  always_comb begin
    w_next        = r_state;
    w_starve_next = r_starve;
    pmem_read     = 1'b0;
    pmem_write    = 1'b0;
    pmem_addr     = '0;
    pmem_wdata    = '0;
    i_pmem_resp   = 1'b0;
    d_pmem_resp   = 1'b0;
    i_pmem_rdata  = '0;
    d_pmem_rdata  = '0;
    case (r_state)
      IDLE: begin
        if (w_d_req && !w_force_i) begin
          w_next = SERVE_D;
          if (w_i_req && r_starve != CW'(STARVE_LIMIT)) begin
            w_starve_next = r_starve + 1'b1;
          end
        end else if (w_i_req) begin
          w_next        = SERVE_I;
          w_starve_next = '0;
        end
      end
      SERVE_I: begin
        pmem_read = 1'b1;
        pmem_addr = i_pmem_addr;
        if (pmem_resp) begin
`ifdef ARB_RDATA_REG_EN
          w_next = RESP_I;
`else
          i_pmem_resp  = 1'b1;
          i_pmem_rdata = pmem_rdata;
          w_next       = IDLE;
`endif
        end
      end
      SERVE_D: begin
        // A writeback takes precedence if the D-cache raises read and write together.
        pmem_read  = d_pmem_read & ~d_pmem_write;
        pmem_write = d_pmem_write;
        pmem_addr  = d_pmem_addr;
        pmem_wdata = d_pmem_wdata;
        if (pmem_resp) begin
`ifdef ARB_RDATA_REG_EN
          w_next = RESP_D;
`else
          d_pmem_resp  = 1'b1;
          d_pmem_rdata = pmem_rdata;
          w_next       = IDLE;
`endif
        end
      end
`ifdef ARB_RDATA_REG_EN
      RESP_I: begin
        i_pmem_resp  = 1'b1;
        i_pmem_rdata = r_rdata;
        w_next       = IDLE;
      end
      RESP_D: begin
        d_pmem_resp  = 1'b1;
        d_pmem_rdata = r_rdata;
        w_next       = IDLE;
      end
`endif
      default: w_next = IDLE;
    endcase
  end

endmodule
